// File: rtl/approx_mac_pe.sv
// approx_mac_pe: output-stationary MAC processing element built around the
// approx_1 4x4 approximate multiplier. Accumulates K_LEN products per dot
// product with saturation, forwards operands to neighbours, and presents the
// finished sum on a valid/ready port.
//
// state | meaning
// ACCUM | accepting operand beats, acc holds the partial sum
// DONE  | result presented on acc_out, waiting for out_ready

// approx_1: 4x4 unsigned approximate multiplier made of four 2x2 blocks.
// Each 2x2 block returns 7 instead of 9 for 3x3, so the largest product is
// 175 (15x15) and the result always fits in 8 bits.
module approx_1 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  function automatic logic [3:0] mul2(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, a[1] & b[1], (a[1] & b[0]) | (a[0] & b[1]), a[0] & b[0]};
  endfunction

  logic [3:0] pp_ll, pp_lh, pp_hl, pp_hh;

  // Partial products and their shifted sum.
  always_comb begin
    pp_ll = mul2(x[1:0], y[1:0]);
    pp_lh = mul2(x[1:0], y[3:2]);
    pp_hl = mul2(x[3:2], y[1:0]);
    pp_hh = mul2(x[3:2], y[3:2]);
    p = {pp_hh, 4'b0000}
      + {2'b00, pp_lh, 2'b00}
      + {2'b00, pp_hl, 2'b00}
      + {4'b0000, pp_ll};
  end

endmodule

module approx_mac_pe #(
  parameter int K_LEN = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a_in,
  input  logic [3:0]       b_in,
  output logic [3:0]       a_out,
  output logic [3:0]       b_out,
  output logic             fwd_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat_flag
);

  localparam int CNT_W = $clog2(K_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);
  localparam logic [ACC_W:0]   MAX_W    = {1'b0, {ACC_W{1'b1}}};

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic             sat, sat_nx;

  logic [7:0]       prod;
  logic [ACC_W:0]   prod_w;
  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] acc_sum, acc_term;
  logic             sum_clip, term_clip;
  logic             beat, out_xfer;

  approx_1 u_mul (
    .x (a_in),
    .y (b_in),
    .p (prod)
  );

  // Clamped running sum and clamped first term of a new dot product.
  always_comb begin
    prod_w    = {{(ACC_W - 7){1'b0}}, prod};
    sum_w     = {1'b0, acc} + prod_w;
    sum_clip  = sum_w[ACC_W];
    acc_sum   = sum_clip ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
    term_clip = (prod_w > MAX_W);
    acc_term  = term_clip ? {ACC_W{1'b1}} : prod_w[ACC_W-1:0];
  end

  // Handshakes and next-state / datapath control.
  always_comb begin
    in_ready  = (state == ACCUM) || out_ready;
    out_valid = (state == DONE);
    beat      = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
    state_nx  = state;
    cnt_nx    = cnt;
    acc_nx    = acc;
    sat_nx    = sat;
    case (state)
      ACCUM: begin
        if (beat) begin
          acc_nx = acc_sum;
          sat_nx = sat | sum_clip;
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = DONE;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_xfer) begin
          if (beat) begin
            acc_nx = acc_term;
            sat_nx = term_clip;
            // With a single-term dot product the new term is already the result.
            if (K_LEN == 1) begin
              cnt_nx   = '0;
              state_nx = DONE;
            end else begin
              cnt_nx   = CNT_W'(1);
              state_nx = ACCUM;
            end
          end else begin
            acc_nx   = '0;
            sat_nx   = 1'b0;
            cnt_nx   = '0;
            state_nx = ACCUM;
          end
        end
      end
      default: state_nx = ACCUM;
    endcase
  end

  // State, counter and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt   <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      acc   <= acc_nx;
      sat   <= sat_nx;
    end
  end

  // Operand forwarding to the east/south neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= 4'd0;
      b_out     <= 4'd0;
      fwd_valid <= 1'b0;
    end else begin
      fwd_valid <= beat;
      if (beat) begin
        a_out <= a_in;
        b_out <= b_in;
      end
    end
  end

  assign acc_out  = acc;
  assign sat_flag = sat;

endmodule

// File: tb/tb_approx_mac_pe.sv
// Testbench for approx_mac_pe: two instances (ACC_W=16 and ACC_W=8) share
// stimulus; a reference model pushes expected dot products into a queue.
module tb_approx_mac_pe;

  localparam int K = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] a_in = 4'd0;
  logic [3:0] b_in = 4'd0;

  logic        in_ready, fwd_valid, out_valid, sat_flag;
  logic [3:0]  a_out, b_out;
  logic [15:0] acc_out;
  logic        in_ready8, fwd_valid8, out_valid8, sat_flag8;
  logic [3:0]  a_out8, b_out8;
  logic [7:0]  acc_out8;

  approx_mac_pe #(.K_LEN(K), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out),
    .fwd_valid(fwd_valid), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .sat_flag(sat_flag)
  );

  approx_mac_pe #(.K_LEN(K), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a_in(a_in), .b_in(b_in), .a_out(a_out8), .b_out(b_out8),
    .fwd_valid(fwd_valid8), .out_valid(out_valid8), .out_ready(out_ready),
    .acc_out(acc_out8), .sat_flag(sat_flag8)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v16;
    int v8;
    bit s16;
    bit s8;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  int m_acc16, m_acc8, m_cnt;
  bit m_sat16, m_sat8, m_done;

  // Products of the approximate multiplier for the operand pairs used here.
  function automatic int ref_prod(input logic [3:0] a, input logic [3:0] b);
    case ({a, b})
      8'h57:   return 35;
      8'h33:   return 7;
      8'hFF:   return 175;
      8'h23:   return 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_acc16 = 0; m_acc8 = 0; m_cnt = 0;
    m_sat16 = 0; m_sat8 = 0; m_done = 0;
    exp_q.delete();
  endtask

  function automatic exp_t head();
    exp_t x;
    if (exp_q.size() > 0) x = exp_q[0];
    else x = '{-1, -1, 1'b1, 1'b1};
    return x;
  endfunction

  // One clock of stimulus, called at a falling edge; advances the model.
  task automatic cyc(input bit v, input logic [3:0] a, input logic [3:0] b);
    bit beat;
    int p;
    in_valid = v;
    a_in = a;
    b_in = b;
    beat = v && (!m_done || out_ready);
    p = ref_prod(a, b);
    if (m_done && out_ready) begin
      void'(exp_q.pop_front());
      m_done = 0; m_acc16 = 0; m_acc8 = 0; m_sat16 = 0; m_sat8 = 0; m_cnt = 0;
    end
    if (beat) begin
      m_acc16 += p;
      if (m_acc16 > 65535) begin m_acc16 = 65535; m_sat16 = 1; end
      m_acc8 += p;
      if (m_acc8 > 255) begin m_acc8 = 255; m_sat8 = 1; end
      m_cnt++;
      if (m_cnt == K) begin
        m_cnt = 0;
        m_done = 1;
        exp_q.push_back('{m_acc16, m_acc8, m_sat16, m_sat8});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, fwd_valid, sat_flag, acc_out, a_out, b_out} !== {4'b1000, 16'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset16 got rdy=%0b ov=%0b fv=%0b sat=%0b acc=%0d a=%0d b=%0d want 1 0 0 0 0 0 0",
               in_ready, out_valid, fwd_valid, sat_flag, acc_out, a_out, b_out);
    end
    checks++;
    if ({in_ready8, out_valid8, fwd_valid8, sat_flag8, acc_out8, a_out8, b_out8} !== {4'b1000, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset8 got rdy=%0b ov=%0b acc=%0d want rdy=1 ov=0 acc=0", in_ready8, out_valid8, acc_out8);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    cyc(1, 4'd5, 4'd7);
    cyc(1, 4'd5, 4'd7);
    checks++;
    if (dut16.cnt !== 3'd2) begin
      errors++;
      $display("FAIL mid_cnt got %0d want 2", dut16.cnt);
    end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, fwd_valid, sat_flag, acc_out, a_out, b_out} !== {4'b1000, 16'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid got rdy=%0b ov=%0b fv=%0b sat=%0b acc=%0d a=%0d b=%0d want 1 0 0 0 0 0 0",
               in_ready, out_valid, fwd_valid, sat_flag, acc_out, a_out, b_out);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || dut16.cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold got ov=%0b cnt=%0d want ov=0 cnt=0", out_valid, dut16.cnt);
    end
    for (int i = 0; i < K; i++) cyc(1, 4'd5, 4'd7);
    e = head();
    checks++;
    if ({out_valid, acc_out, sat_flag} !== {1'b1, 16'(e.v16), e.s16}) begin
      errors++;
      $display("FAIL post_reset_sum got ov=%0b acc=%0d sat=%0b want ov=1 acc=%0d sat=%0b",
               out_valid, acc_out, sat_flag, e.v16, e.s16);
    end
    cyc(0, 4'd0, 4'd0);
    checks++;
    if (out_valid !== 1'b0 || acc_out !== 16'd0) begin
      errors++;
      $display("FAIL drain got ov=%0b acc=%0d want ov=0 acc=0", out_valid, acc_out);
    end
  endtask

  task automatic test_approx();
    out_ready = 1'b0;
    for (int i = 0; i < K - 1; i++) cyc(1, 4'd3, 4'd3);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL approx_early got ov=%0b want 0", out_valid);
    end
    cyc(1, 4'd3, 4'd3);
    e = head();
    checks++;
    if ({out_valid, acc_out, sat_flag} !== {1'b1, 16'(e.v16), e.s16}) begin
      errors++;
      $display("FAIL approx16 got ov=%0b acc=%0d sat=%0b want ov=1 acc=%0d sat=%0b",
               out_valid, acc_out, sat_flag, e.v16, e.s16);
    end
    checks++;
    if ({out_valid8, acc_out8, sat_flag8} !== {1'b1, 8'(e.v8), e.s8}) begin
      errors++;
      $display("FAIL approx8 got ov=%0b acc=%0d sat=%0b want ov=1 acc=%0d sat=%0b",
               out_valid8, acc_out8, sat_flag8, e.v8, e.s8);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || in_ready8 !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready cycle %0d got %0b/%0b want 0", i, in_ready, in_ready8);
      end
      cyc(1, 4'd3, 4'd3);
      e = head();
      checks++;
      if ({out_valid, fwd_valid, acc_out, dut16.cnt} !== {2'b10, 16'(e.v16), 3'd0}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got ov=%0b fv=%0b acc=%0d cnt=%0d want ov=1 fv=0 acc=%0d cnt=0",
                 i, out_valid, fwd_valid, acc_out, dut16.cnt, e.v16);
      end
    end
    out_ready = 1'b1;
    cyc(0, 4'd0, 4'd0);
    checks++;
    if (out_valid !== 1'b0 || acc_out !== 16'd0 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got ov=%0b acc=%0d sat=%0b want ov=0 acc=0 sat=0", out_valid, acc_out, sat_flag);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 2 * K; i++) begin
      cyc(1, 4'hF, 4'hF);
      checks++;
      if (fwd_valid !== 1'b1 || out_valid !== ((i % K) == 0)) begin
        errors++;
        $display("FAIL b2b_flags beat %0d got fv=%0b ov=%0b want fv=1 ov=%0b", i, fwd_valid, out_valid, (i % K) == 0);
      end
      if ((i % K) == 0) begin
        e = head();
        checks++;
        if ({acc_out, sat_flag, acc_out8, sat_flag8} !== {16'(e.v16), e.s16, 8'(e.v8), e.s8}) begin
          errors++;
          $display("FAIL b2b_result beat %0d got %0d/%0b %0d/%0b want %0d/%0b %0d/%0b",
                   i, acc_out, sat_flag, acc_out8, sat_flag8, e.v16, e.s16, e.v8, e.s8);
        end
      end
    end
    cyc(0, 4'd0, 4'd0);
  endtask

  task automatic test_gapped();
    out_ready = 1'b1;
    for (int i = 0; i < 2 * K; i++) begin
      cyc(((i % 2) == 0), 4'd2, 4'd3);
      checks++;
      if ({fwd_valid, a_out, b_out, out_valid} !== {((i % 2) == 0), 4'd2, 4'd3, (i == 2 * K - 2)}) begin
        errors++;
        $display("FAIL gapped cycle %0d got fv=%0b a=%0d b=%0d ov=%0b want fv=%0b a=2 b=3 ov=%0b",
                 i, fwd_valid, a_out, b_out, out_valid, (i % 2) == 0, i == 2 * K - 2);
      end
      if (i == 2 * K - 2) begin
        e = head();
        checks++;
        if ({acc_out, sat_flag} !== {16'(e.v16), e.s16}) begin
          errors++;
          $display("FAIL gapped_result got acc=%0d sat=%0b want acc=%0d sat=%0b", acc_out, sat_flag, e.v16, e.s16);
        end
      end
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < K; i++) cyc(1, 4'hF, 4'hF);
    e = head();
    checks++;
    if ({out_valid8, acc_out8, sat_flag8} !== {1'b1, 8'(e.v8), e.s8}) begin
      errors++;
      $display("FAIL sat8 got ov=%0b acc=%0d sat=%0b want ov=1 acc=%0d sat=%0b",
               out_valid8, acc_out8, sat_flag8, e.v8, e.s8);
    end
    checks++;
    if ({acc_out, sat_flag} !== {16'(e.v16), e.s16}) begin
      errors++;
      $display("FAIL sat16 got acc=%0d sat=%0b want acc=%0d sat=%0b", acc_out, sat_flag, e.v16, e.s16);
    end
    for (int i = 0; i < K; i++) cyc(1, 4'd2, 4'd3);
    e = head();
    checks++;
    if ({out_valid8, acc_out8, sat_flag8} !== {1'b1, 8'(e.v8), e.s8}) begin
      errors++;
      $display("FAIL after_sat8 got ov=%0b acc=%0d sat=%0b want ov=1 acc=%0d sat=%0b",
               out_valid8, acc_out8, sat_flag8, e.v8, e.s8);
    end
    cyc(0, 4'd0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_approx();
    test_stall();
    test_back_to_back();
    test_gapped();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
